// File: rtl/pwm_dac_pkg.sv
// Shared types and constants for the PWM DAC output stage.
package pwm_dac_pkg;

  // Occupancy of the single-entry sample hold register.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  localparam int PWM_DW_DEF = 4;

  // Number of ticks in one PWM period for a given sample width.
  function automatic int period_len(input int dw);
    return 2 ** dw;
  endfunction

endpackage

// File: rtl/pwm_dac_prescaler.sv
// Divides clk down to a one-cycle PWM tick every PRESC clocks.
module pwm_dac_prescaler #(
  parameter int PRESC = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(PRESC - 1);

  logic [CW-1:0] pre_cnt_q;
  logic [CW-1:0] pre_cnt_d;

  // Tick on the last count of each prescale window, then wrap to zero.
  always_comb begin
    tick      = (pre_cnt_q == PRE_LAST);
    pre_cnt_d = tick ? '0 : pre_cnt_q + CW'(1);
  end

  // Prescale counter register.
  always_ff @(posedge clk) begin
    if (rst) pre_cnt_q <= '0;
    else     pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/pwm_dac_stage.sv
// PWM DAC output stage: takes DW-bit codes over valid/ready and turns them
// into a PWM stream whose duty is code/2^DW. New codes only load at period
// boundaries so a single period never mixes two codes.
// Optional macro PWM_DAC_COMP_OUT_EN adds the complementary output pwm_out_n.
//
// Handshake: a sample transfers on any rising edge where din_valid and
// din_ready are both high; din_ready depends only on hold occupancy and rst,
// never on din_valid, and the upstream stage must hold din stable until then.
module pwm_dac_stage
  import pwm_dac_pkg::*;
#(
  parameter int DW    = PWM_DW_DEF,
  parameter int PRESC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          pwm_out,
  output logic          period_start,
  output logic          underrun
`ifdef PWM_DAC_COMP_OUT_EN
  ,
  output logic          pwm_out_n
`endif
);

  localparam logic [DW-1:0] TICK_LAST = DW'(period_len(DW) - 1);

  logic          tick;
  logic          boundary;
  logic [DW-1:0] tick_cnt_q, tick_cnt_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  hold_state_e   hold_state_q, hold_state_d;
  logic          bnd_q, bnd_d;
  logic          bnd_und_q, bnd_und_d;
  logic          pwm_q, pwm_d;
  logic          ps_q, ps_d;
  logic          und_q, und_d;

  pwm_dac_prescaler #(.PRESC(PRESC)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Tick counter, hold FSM, duty transfer and comparator next-state.
  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    duty_d       = duty_q;
    hold_data_d  = hold_data_q;
    hold_state_d = hold_state_q;

    boundary  = tick && (tick_cnt_q == TICK_LAST);
    din_ready = (hold_state_q == HOLD_EMPTY) && !rst;

    if (tick) tick_cnt_d = tick_cnt_q + DW'(1);

    // Remember that a period began (and whether it began starved) so the
    // markers can line up with the first compare result of that period.
    bnd_d     = boundary;
    bnd_und_d = boundary && (hold_state_q == HOLD_EMPTY);

    case (hold_state_q)
      HOLD_EMPTY: begin
        if (din_valid && din_ready) begin
          hold_data_d  = din;
          hold_state_d = HOLD_FULL;
        end
      end
      HOLD_FULL: begin
        if (boundary) begin
          duty_d       = hold_data_q;
          hold_state_d = HOLD_EMPTY;
        end
      end
      default: hold_state_d = HOLD_EMPTY;
    endcase

    pwm_d = (tick_cnt_q < duty_q);
    ps_d  = bnd_q;
    und_d = bnd_und_q;
  end

  // State registers. Reset counts as the start of a period with nothing held,
  // so the first period after reset is marked like any other.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      duty_q       <= '0;
      hold_data_q  <= '0;
      hold_state_q <= HOLD_EMPTY;
      bnd_q        <= 1'b1;
      bnd_und_q    <= 1'b1;
      pwm_q        <= 1'b0;
      ps_q         <= 1'b0;
      und_q        <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      duty_q       <= duty_d;
      hold_data_q  <= hold_data_d;
      hold_state_q <= hold_state_d;
      bnd_q        <= bnd_d;
      bnd_und_q    <= bnd_und_d;
      pwm_q        <= pwm_d;
      ps_q         <= ps_d;
      und_q        <= und_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign underrun     = und_q;

`ifdef PWM_DAC_COMP_OUT_EN
  logic pwm_n_q;

  // Complementary output from the same compare result, so it is always the
  // exact inverse of pwm_out with no dead time.
  always_ff @(posedge clk) begin
    if (rst) pwm_n_q <= 1'b1;
    else     pwm_n_q <= ~pwm_d;
  end

  assign pwm_out_n = pwm_n_q;
`endif

endmodule

// File: tb/tb_pwm_dac_stage.sv
// Bench for pwm_dac_stage: PRESC=1 and PRESC=3 instances share stimulus; one
// is selected for checking at a time against a period-level reference model.
module tb_pwm_dac_stage;

  localparam int DW = 4;
  localparam int PL = 16;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rdy1, pwm1, ps1, und1;
  logic          rdy3, pwm3, ps3, und3;
`ifdef PWM_DAC_COMP_OUT_EN
  logic          pwmn1, pwmn3;
`endif

  pwm_dac_stage #(.DW(DW), .PRESC(1)) u_dut1 (
    .clk (clk), .rst (rst), .din (din), .din_valid (din_valid),
    .din_ready (rdy1), .pwm_out (pwm1), .period_start (ps1), .underrun (und1)
`ifdef PWM_DAC_COMP_OUT_EN
    , .pwm_out_n (pwmn1)
`endif
  );

  pwm_dac_stage #(.DW(DW), .PRESC(3)) u_dut3 (
    .clk (clk), .rst (rst), .din (din), .din_valid (din_valid),
    .din_ready (rdy3), .pwm_out (pwm3), .period_start (ps3), .underrun (und3)
`ifdef PWM_DAC_COMP_OUT_EN
    , .pwm_out_n (pwmn3)
`endif
  );

  int mp = 1;  // prescale of the instance under check
  logic a_rdy, a_pwm, a_ps, a_und;
  assign a_rdy = (mp == 1) ? rdy1 : rdy3;
  assign a_pwm = (mp == 1) ? pwm1 : pwm3;
  assign a_ps  = (mp == 1) ? ps1  : ps3;
  assign a_und = (mp == 1) ? und1 : und3;
`ifdef PWM_DAC_COMP_OUT_EN
  logic a_pwmn;
  assign a_pwmn = (mp == 1) ? pwmn1 : pwmn3;
`endif

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: samples waiting in hold, and the duty/underrun decided
  // for each period index since the last reset.
  logic [DW-1:0] exp_q[$];
  int            mk;          // clock edges since reset release
  int            mduty[512];
  bit            mund[512];
  bit            last_accept;

  // Directed observations
  int hi_cnt, hi_started, last_ps_k, und_cnt;
  int hi_q[$];
  int gap_q[$];

  function automatic int hi_at(input int i);
    return (i < hi_q.size()) ? hi_q[i] : -1;
  endfunction

  function automatic int gap_at(input int i);
    return (i < gap_q.size()) ? gap_q[i] : -1;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic v, input logic [DW-1:0] d,
                       input bit use_tbl, input logic t_rdy, input logic t_pwm,
                       input logic t_ps, input logic t_und);
    logic e_rdy, e_pwm, e_ps, e_und;
    int k, plen, p, c, pp;
    rst = r; din_valid = v; din = d;
    #1;
    e_rdy = !r && (exp_q.size() == 0);
    chk("din_ready", a_rdy, e_rdy);
    if (use_tbl) chk("tbl_din_ready", a_rdy, t_rdy);
    last_accept = e_rdy && v;
    if (r) begin
      exp_q.delete();
      mk = 0; mduty[0] = 0; mund[0] = 1'b1;
      e_pwm = 0; e_ps = 0; e_und = 0;
    end else begin
      k = mk + 1;
      plen = PL * mp;
      if (k % plen == 0) begin
        p = (k / plen) % 512;
        if (exp_q.size() > 0) begin
          mduty[p] = exp_q.pop_front();
          mund[p]  = 1'b0;
        end else begin
          mduty[p] = mduty[(p + 511) % 512];
          mund[p]  = 1'b1;
        end
      end
      if (last_accept) exp_q.push_back(d);
      c  = k - 1;
      pp = (c / plen) % 512;
      e_pwm = (((c / mp) % PL) < mduty[pp]);
      e_ps  = ((c % plen) == 0);
      e_und = e_ps && mund[pp];
      mk = k;
    end
    @(posedge clk); #1;
    chk("pwm_out", a_pwm, e_pwm);
    chk("period_start", a_ps, e_ps);
    chk("underrun", a_und, e_und);
`ifdef PWM_DAC_COMP_OUT_EN
    chk("pwm_out_n", a_pwmn, r ? 1'b1 : ~e_pwm);
`endif
    if (use_tbl) begin
      chk("tbl_pwm_out", a_pwm, t_pwm);
      chk("tbl_period_start", a_ps, t_ps);
      chk("tbl_underrun", a_und, t_und);
    end
    if (r) begin
      hi_started = 0; hi_cnt = 0; last_ps_k = -1;
      hi_q.delete(); gap_q.delete();
    end else begin
      if (a_ps === 1'b1) begin
        if (hi_started != 0) hi_q.push_back(hi_cnt);
        if (last_ps_k >= 0) gap_q.push_back(mk - last_ps_k);
        hi_started = 1; hi_cnt = 0; last_ps_k = mk;
      end
      if (a_pwm === 1'b1) hi_cnt++;
      if (a_und === 1'b1) und_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, DW'($urandom), 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 1'($urandom), DW'($urandom), 0, 0, 0, 0, 0);
  endtask

  // Holds the sample valid until accepted; returns the accepting edge index.
  task automatic send(input logic [DW-1:0] d, output int acc_k);
    acc_k = -1;
    for (int i = 0; i < 200 && acc_k < 0; i++) begin
      cycle(1'b0, 1'b1, d, 0, 0, 0, 0, 0);
      if (last_accept) acc_k = mk;
    end
    if (acc_k < 0) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no acceptance expected acceptance of %0d", d);
    end
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic          r;
    logic          v;
    logic [DW-1:0] d;
    logic          rdy;
    logic          pwm;
    logic          ps;
    logic          und;
  } vec_t;

  vec_t tbl[22];

  initial begin
    int a, b;
    und_cnt = 0; hi_started = 0; hi_cnt = 0; last_ps_k = -1;

    // Reset/idle vectors: 5 clk reset, then 17 idle edges after release.
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 5; i < 22; i++) begin
      tbl[i] = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0,
                 (i == 5) || (i == 21), (i == 5) || (i == 21)};
    end

    mp = 1;
    for (int i = 0; i < 22; i++)
      cycle(tbl[i].r, tbl[i].v, tbl[i].d, 1, tbl[i].rdy, tbl[i].pwm, tbl[i].ps, tbl[i].und);
    idle(20);

    // Duty sweep: one code per period.
    do_reset(3);
    send(4'd0, a);  chk("sweep_acc0", a, 1);
    send(4'd1, a);  chk("sweep_acc1", a, 17);
    send(4'd8, a);  chk("sweep_acc8", a, 33);
    send(4'd15, a); chk("sweep_acc15", a, 49);
    idle(40);
    chk("sweep_hi_p0", hi_at(0), 0);
    chk("sweep_hi_p1", hi_at(1), 0);
    chk("sweep_hi_p2", hi_at(2), 1);
    chk("sweep_hi_p3", hi_at(3), 8);
    chk("sweep_hi_p4", hi_at(4), 15);

    // Backpressure: continuous valid, 3 then 12.
    do_reset(2);
    send(4'd3, a);
    send(4'd12, b);
    chk("bp_acc3", a, 1);
    chk("bp_acc12", b, 17);
    idle(40);
    chk("bp_hi_p1", hi_at(1), 3);
    chk("bp_hi_p2", hi_at(2), 12);

    // Underrun: 10 then nothing.
    do_reset(2);
    send(4'd10, a);
    und_cnt = 0;
    idle(70);
    chk("ur_hi_p1", hi_at(1), 10);
    chk("ur_hi_p2", hi_at(2), 10);
    chk("ur_hi_p3", hi_at(3), 10);
    chk("ur_pulses", und_cnt, 3);

    // Reset at tick 5 of a duty-12 period.
    do_reset(2);
    send(4'd12, a);
    idle(20);
    cycle(1'b1, 1'b0, 4'd0, 0, 0, 0, 0, 0);
    chk("midrst_pwm", a_pwm, 0);
    idle(40);
    chk("midrst_hi_p0", hi_at(0), 0);
    chk("midrst_gap", gap_at(0), 16);

    // PRESC=3 instance, code 4.
    mp = 3;
    do_reset(3);
    send(4'd4, a);
    idle(150);
    chk("p3_hi_p1", hi_at(1), 12);
    chk("p3_gap0", gap_at(0), 48);
    chk("p3_gap1", gap_at(1), 48);
    for (int i = 0; i < 150; i++)
      cycle(1'b0, ($urandom_range(0, 3) == 0), DW'($urandom), 0, 0, 0, 0, 0);

    // Randomised traffic on PRESC=1 with occasional resets.
    mp = 1;
    do_reset(2);
    for (int i = 0; i < 500; i++)
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) == 0),
            DW'($urandom), 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
